// File: rtl/i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_tx                                                          |
// | Summary  : I2S slave transmitter with a one-pair stream holding buffer.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module i2s_tx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ws,
  output logic             sd,
  input  logic [WIDTH-1:0] input_l_tdata,
  input  logic [WIDTH-1:0] input_r_tdata,
  input  logic             input_tvalid,
  output logic             input_tready,
  output logic             underrun
);

  localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               r_last_sck;
  logic               r_ws_s;
  logic               r_ws_p;
  logic               r_sd;
  logic               r_underrun;
  logic               r_buf_valid;
  logic [WIDTH-1:0]   r_buf_l;
  logic [WIDTH-1:0]   r_buf_r;
  logic [WIDTH-1:0]   r_sreg;
  logic [WIDTH-1:0]   r_hold;
  logic [c_cnt_w-1:0] r_bit_cnt;

  logic w_rise;
  logic w_fall;
  logic w_start;
  logic w_hs;

  assign w_rise  = ~r_last_sck & sck;
  assign w_fall  = r_last_sck & ~sck;
  assign w_start = r_ws_s != r_ws_p;
  assign w_hs    = input_tvalid & ~r_buf_valid;

  assign sd           = r_sd;
  assign underrun     = r_underrun;
  assign input_tready = ~r_buf_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_sck  <= 1'b0;
      r_ws_s      <= 1'b0;
      r_ws_p      <= 1'b0;
      r_sd        <= 1'b0;
      r_underrun  <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_l     <= '0;
      r_buf_r     <= '0;
      r_sreg      <= '0;
      r_hold      <= '0;
      r_bit_cnt   <= '0;
    end else begin
      r_last_sck <= sck;
      r_underrun <= 1'b0;

      // ws is only stable around the rising edge, so sample it there.
      if (w_rise) begin
        r_ws_s <= ws;
      end

      if (w_fall) begin
        r_ws_p <= r_ws_s;
        if (w_start) begin
          r_bit_cnt <= c_last_bit;
          if (!r_ws_s) begin
            if (r_buf_valid) begin
              r_sreg      <= r_buf_l;
              r_hold      <= r_buf_r;
              r_sd        <= r_buf_l[WIDTH-1];
              r_buf_valid <= 1'b0;
            end else begin
              r_sreg     <= '0;
              r_hold     <= '0;
              r_sd       <= 1'b0;
              r_underrun <= 1'b1;
            end
          end else begin
            // Right word always pairs with the left word already sent.
            r_sreg <= r_hold;
            r_sd   <= r_hold[WIDTH-1];
          end
        end else if (r_bit_cnt != '0) begin
          r_sd      <= r_sreg[WIDTH-2];
          r_sreg    <= {r_sreg[WIDTH-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt - c_cnt_one;
        end else begin
          r_sd <= 1'b0;
        end
      end

      // Only possible while the buffer is empty, so never collides with the clear above.
      if (w_hs) begin
        r_buf_l     <= input_l_tdata;
        r_buf_r     <= input_r_tdata;
        r_buf_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// Directed bench for i2s_tx: acts as the I2S master, drives the sample stream and
// recovers words with a small I2S receiver compared against a queue of expected words.
module tb_i2s_tx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sck = 1'b0;
  logic         ws  = 1'b0;
  logic         sd;
  logic [W-1:0] input_l_tdata = '0;
  logic [W-1:0] input_r_tdata = '0;
  logic         input_tvalid  = 1'b0;
  logic         input_tready;
  logic         underrun;

  i2s_tx #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .sck           (sck),
    .ws            (ws),
    .sd            (sd),
    .input_l_tdata (input_l_tdata),
    .input_r_tdata (input_r_tdata),
    .input_tvalid  (input_tvalid),
    .input_tready  (input_tready),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event monitors
  int ur_cnt  = 0;
  int acc_cnt = 0;
  always @(negedge clk) begin
    if (underrun === 1'b1) ur_cnt++;
    if (input_tvalid && input_tready === 1'b1) acc_cnt++;
  end

  // Receiver model: a word starts one sck after the ws transition, MSB first.
  logic [W-1:0] exp_q[$];
  bit           rx_en      = 1'b1;
  bit           rx_started = 1'b0;
  logic         rx_prev_ws = 1'b0;
  logic         rx_owner   = 1'b0;
  logic [W-1:0] rx_word    = '0;
  int           rx_cnt     = 0;
  int           rx_seq     = 0;
  int           pad_errs   = 0;
  int           rx_extra   = 0;

  task automatic rx_reset();
    rx_started = 1'b0;
    rx_prev_ws = ws;
    rx_owner   = ws;
    rx_cnt     = 0;
    rx_word    = '0;
  endtask

  task automatic rx_done();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      rx_extra++;
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("rx_word%0d_%s", rx_seq, rx_owner ? "R" : "L"), 32'(rx_word), 32'(e));
    end
    rx_seq++;
  endtask

  task automatic rx_bit(input logic b, input logic w);
    logic owner;
    owner = rx_prev_ws;
    if (owner != rx_owner) begin
      if (rx_started) rx_done();
      rx_started = 1'b1;
      rx_cnt     = 0;
      rx_word    = '0;
    end
    if (rx_cnt < W) rx_word = {rx_word[W-2:0], b};
    else if (b) pad_errs++;
    rx_cnt++;
    rx_owner   = owner;
    rx_prev_ws = w;
  endtask

  // Master: one sck period is 4 clk; ws changes with the falling edge.
  logic [W-1:0] inj_l = '0;
  logic [W-1:0] inj_r = '0;

  task automatic sck_cycle(input logic w, input bit inj);
    logic b;
    @(posedge clk); #1;
    sck = 1'b0;
    ws  = w;
    if (inj) begin
      input_tvalid  = 1'b1;
      input_l_tdata = inj_l;
      input_r_tdata = inj_r;
    end
    @(posedge clk); #1;
    if (inj) begin
      chk("sim_underrun_pulse", 32'(underrun), 32'd1);
      input_tvalid = 1'b0;
    end
    @(posedge clk); #1;
    b   = sd;
    sck = 1'b1;
    if (rx_en) rx_bit(b, w);
    @(posedge clk); #1;
  endtask

  task automatic send_channel(input logic w, input int n, input bit inj_en = 1'b0);
    for (int k = 0; k < n; k++) sck_cycle(w, inj_en && (k == 1));
  endtask

  task automatic frame(input int n);
    send_channel(1'b0, n);
    send_channel(1'b1, n);
  endtask

  // Must be entered just after a rising clk edge.
  task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    bit done;
    done          = 1'b0;
    input_tvalid  = 1'b1;
    input_l_tdata = l;
    input_r_tdata = r;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (input_tready === 1'b1) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) chk("push_timeout", 32'(input_tready), 32'd1);
    input_tvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int ur0;
  int acc0;

  initial begin
    // Reset while the bit clock runs
    send_channel(1'b1, 3);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_sd", 32'(sd), 32'd0);
    chk("rst_tready", 32'(input_tready), 32'd1);
    chk("rst_underrun", 32'(underrun), 32'd0);

    // Basic frame; the first right word after reset carries r_hold=0
    rx_reset();
    push_pair(16'hA5C3, 16'h1234);
    send_channel(1'b1, 4);
    chk("first_right_sd", 32'(sd), 32'd0);
    ur0 = ur_cnt;
    exp_q.push_back(16'hA5C3);
    exp_q.push_back(16'h1234);
    frame(16);
    chk("basic_underrun", 32'(ur_cnt - ur0), 32'd0);
    chk("basic_tready", 32'(input_tready), 32'd1);

    // Long frame: 32 sck per channel, 16 padding zeros per word
    push_pair(16'h8001, 16'h7FFE);
    ur0 = ur_cnt;
    exp_q.push_back(16'h8001);
    exp_q.push_back(16'h7FFE);
    frame(32);
    chk("long_underrun", 32'(ur_cnt - ur0), 32'd0);

    // Underrun, with a pair offered mid-frame
    ur0 = ur_cnt;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    send_channel(1'b0, 8);
    push_pair(16'hC0DE, 16'hBEEF);
    send_channel(1'b0, 8);
    send_channel(1'b1, 16);
    chk("underrun_pulse_count", 32'(ur_cnt - ur0), 32'd1);
    chk("underrun_tready_pending", 32'(input_tready), 32'd0);
    exp_q.push_back(16'hC0DE);
    exp_q.push_back(16'hBEEF);
    frame(16);
    chk("underrun_no_repeat", 32'(ur_cnt - ur0), 32'd1);

    // Back-pressure: tvalid held high with incrementing pairs
    ur0  = ur_cnt;
    acc0 = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(W'(16'h1000 + i));
      exp_q.push_back(W'(16'h2000 + i));
    end
    fork
      begin
        for (int i = 0; i < 8; i++) push_pair(W'(16'h1000 + i), W'(16'h2000 + i));
      end
      begin
        for (int f = 0; f < 8; f++) begin
          send_channel(1'b0, 16);
          chk($sformatf("bp_tready_f%0d", f), 32'(input_tready), (f == 7) ? 32'd1 : 32'd0);
          send_channel(1'b1, 16);
        end
      end
    join
    chk("bp_accepts", 32'(acc_cnt - acc0), 32'd8);
    chk("bp_underrun", 32'(ur_cnt - ur0), 32'd0);

    // Pair presented in the exact clk of the left word start
    inj_l = 16'h1357;
    inj_r = 16'h9BDF;
    ur0   = ur_cnt;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    send_channel(1'b0, 16, 1'b1);
    send_channel(1'b1, 16);
    chk("sim_tready", 32'(input_tready), 32'd0);
    chk("sim_underrun_count", 32'(ur_cnt - ur0), 32'd1);
    exp_q.push_back(16'h1357);
    exp_q.push_back(16'h9BDF);
    frame(16);

    // Reset in the middle of a word
    push_pair(16'hFFFF, 16'hFFFF);
    send_channel(1'b0, 6);
    chk("pre_rst_sd", 32'(sd), 32'd1);
    chk("pre_rst_queue", 32'(exp_q.size()), 32'd0);
    rx_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_sd", 32'(sd), 32'd0);
    chk("midrst_tready", 32'(input_tready), 32'd1);
    rst = 1'b0;
    rx_reset();
    rx_en = 1'b1;
    send_channel(1'b0, 10);
    chk("post_rst_sd", 32'(sd), 32'd0);
    push_pair(16'h0F0F, 16'hF0F0);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0F0F);
    exp_q.push_back(16'hF0F0);
    send_channel(1'b1, 16);
    send_channel(1'b0, 16);
    send_channel(1'b1, 16);
    send_channel(1'b0, 2);

    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("rx_extra_words", 32'(rx_extra), 32'd0);
    chk("pad_bits_nonzero", 32'(pad_errs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
